// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand issue and result handshake bundle for alu_mc
interface alu_mc_if #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [OP_W-1:0]  Card;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] F;
   logic             Cout;
   logic             Zero;

   modport master (
      output in_valid, A, B, Cin, Card, out_ready,
      input  in_ready, out_valid, F, Cout, Zero
   );

   modport slave (
      input  in_valid, A, B, Cin, Card, out_ready,
      output in_ready, out_valid, F, Cout, Zero
   );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: 1-cycle simple ops, shift-add MUL, restoring DIVU/REMU
// Signed MULS/DIVS/REMS are built only when ALU_MC_SIGNED_EN is defined.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 5
) (
   input  logic    clk,
   input  logic    rst,
   alu_mc_if.slave bus
);
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_ADDC  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUBC  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_NOR   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
   localparam logic [OP_W-1:0] OP_SRA   = OP_W'(10);
   localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_PASSA = OP_W'(12);
   localparam logic [OP_W-1:0] OP_PASSB = OP_W'(13);
   localparam logic [OP_W-1:0] OP_MUL   = OP_W'(14);
   localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(15);
   localparam logic [OP_W-1:0] OP_REMU  = OP_W'(16);
`ifdef ALU_MC_SIGNED_EN
   localparam logic [OP_W-1:0] OP_MULS  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_DIVS  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_REMS  = OP_W'(19);
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] f_q, res_f;
   logic             cout_q, zero_q, res_c, load;
   logic [WIDTH-1:0] acc_q, acc_n, lo_q, lo_n, b_q, b_n;
   logic [OP_W-1:0]  op_q, op_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             in_ready, accept, iter_start, op_is_mul;
   logic [WIDTH-1:0] s_f, fin_f, it_acc, it_lo;
   logic             s_c, fin_c;
   logic [SH_W-1:0]  amt;
   logic [WIDTH:0]   shl, srl, sra, mul_sum, div_sh, div_diff;
`ifdef ALU_MC_SIGNED_EN
   logic               neg_q, neg_n, ovf_q, ovf_n, signed_in;
   logic [2*WIDTH-1:0] prod;
`endif

   assign in_ready      = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
   assign accept        = bus.in_valid & in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == S_DONE);
   assign bus.F         = f_q;
   assign bus.Cout      = cout_q;
   assign bus.Zero      = zero_q;

   // Single-cycle results straight from the live operands, registered on accept.
   always_comb begin
      s_f = '0;
      s_c = 1'b0;
      amt = bus.B[SH_W-1:0];
      shl = {1'b0, bus.A} << amt;
      srl = {bus.A, 1'b0} >> amt;
      sra = $signed({bus.A, 1'b0}) >>> amt;
      case (bus.Card)
         OP_ADD:   {s_c, s_f} = {1'b0, bus.A} + {1'b0, bus.B};
         OP_ADDC:  {s_c, s_f} = {1'b0, bus.A} + {1'b0, bus.B} + (WIDTH+1)'(bus.Cin);
         OP_SUB:   {s_c, s_f} = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
         OP_SUBC:  {s_c, s_f} = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(!bus.Cin);
         OP_AND:   s_f = bus.A & bus.B;
         OP_OR:    s_f = bus.A | bus.B;
         OP_XOR:   s_f = bus.A ^ bus.B;
         OP_NOR:   s_f = ~(bus.A | bus.B);
         OP_SLL:   {s_c, s_f} = shl;
         OP_SRL:   {s_f, s_c} = srl;
         OP_SRA:   {s_f, s_c} = sra;
         OP_SLTU:  s_f = WIDTH'(bus.A < bus.B);
         OP_PASSA: s_f = bus.A;
         OP_PASSB: s_f = bus.B;
`ifdef ALU_MC_SIGNED_EN
         OP_DIVU, OP_DIVS: begin
`else
         OP_DIVU: begin
`endif
            if (bus.B == '0) begin
               s_f = '1;
               s_c = 1'b1;
            end
         end
`ifdef ALU_MC_SIGNED_EN
         OP_REMU, OP_REMS: begin
`else
         OP_REMU: begin
`endif
            if (bus.B == '0) begin
               s_f = bus.A;
               s_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      op_is_mul  = (op_q == OP_MUL);
      iter_start = (bus.Card == OP_MUL) |
                   (((bus.Card == OP_DIVU) | (bus.Card == OP_REMU)) & (bus.B != '0));
`ifdef ALU_MC_SIGNED_EN
      op_is_mul  = op_is_mul | (op_q == OP_MULS);
      signed_in  = (bus.Card == OP_MULS) | (bus.Card == OP_DIVS) | (bus.Card == OP_REMS);
      iter_start = iter_start | (bus.Card == OP_MULS) |
                   (((bus.Card == OP_DIVS) | (bus.Card == OP_REMS)) & (bus.B != '0));
`endif
   end

   // acc holds the product high half / partial remainder, lo the multiplier / quotient.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {acc_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      if (op_is_mul) begin
         it_acc = mul_sum[WIDTH:1];
         it_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
         it_acc = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
         it_lo  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end
   end

   always_comb begin
      fin_f = it_lo;
      fin_c = 1'b0;
`ifdef ALU_MC_SIGNED_EN
      prod  = {it_acc, it_lo};
      if (neg_q) prod = -prod;
`endif
      case (op_q)
         OP_MUL:  fin_c = |it_acc;
         OP_REMU: fin_f = it_acc;
`ifdef ALU_MC_SIGNED_EN
         OP_MULS: begin
            fin_f = prod[WIDTH-1:0];
            fin_c = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
         end
         OP_DIVS: begin
            fin_f = neg_q ? -it_lo : it_lo;
            fin_c = ovf_q;
         end
         OP_REMS: begin
            fin_f = neg_q ? -it_acc : it_acc;
            fin_c = ovf_q;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      res_f   = s_f;
      res_c   = s_c;
      acc_n   = acc_q;
      lo_n    = lo_q;
      b_n     = b_q;
      op_n    = op_q;
      cnt_n   = cnt_q;
`ifdef ALU_MC_SIGNED_EN
      neg_n   = neg_q;
      ovf_n   = ovf_q;
`endif
      case (state)
         S_BUSY: begin
            acc_n = it_acc;
            lo_n  = it_lo;
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_n = S_DONE;
               load    = 1'b1;
               res_f   = fin_f;
               res_c   = fin_c;
            end
         end
         S_DONE: if (bus.out_ready) state_n = S_IDLE;
         default: ;
      endcase
      if (accept) begin
         op_n  = bus.Card;
         cnt_n = '0;
         acc_n = '0;
         lo_n  = bus.A;
         b_n   = bus.B;
`ifdef ALU_MC_SIGNED_EN
         if (signed_in) begin
            lo_n  = bus.A[WIDTH-1] ? -bus.A : bus.A;
            b_n   = bus.B[WIDTH-1] ? -bus.B : bus.B;
            neg_n = (bus.Card == OP_REMS) ? bus.A[WIDTH-1] : (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            ovf_n = (bus.Card != OP_MULS) & (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.B == '1);
         end
`endif
         if (iter_start) begin
            state_n = S_BUSY;
         end else begin
            state_n = S_DONE;
            load    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         f_q    <= '0;
         cout_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            f_q    <= res_f;
            cout_q <= res_c;
            zero_q <= (res_f == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_n;
      cnt_q <= cnt_n;
      acc_q <= acc_n;
      lo_q  <= lo_n;
      b_q   <= b_n;
`ifdef ALU_MC_SIGNED_EN
      neg_q <= neg_n;
      ovf_q <= ovf_n;
`endif
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc: directed vectors, hold/back-to-back, abort, opcode sweep
module tb_alu_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mc_if #(.WIDTH(W), .OP_W(5)) ifc ();

   alu_mc #(.WIDTH(W), .OP_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic [W-1:0] f;
      logic         c;
      logic         z;
      int           lat;
      int           acc;
      string        name;
   } exp_t;

   exp_t sb[$];
   bit   seen = 0;
   int   first = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops one expectation per output handshake; latency from first out_valid sighting.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            seen = 0;
         end else if (ifc.out_valid) begin
            if (!seen) begin
               seen  = 1;
               first = cyc;
            end
            if (ifc.out_ready) begin
               check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check({e.name, "_F"}, 64'(ifc.F), 64'(e.f));
                  check({e.name, "_Cout"}, 64'(ifc.Cout), 64'(e.c));
                  check({e.name, "_Zero"}, 64'(ifc.Zero), 64'(e.z));
                  check({e.name, "_lat"}, 64'(first - e.acc + 1), 64'(e.lat));
               end
               seen = 0;
            end
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] ef, input logic ec, input int lat,
                        input string name, input bit push);
      int n = 0;
      ifc.in_valid = 1'b1;
      ifc.Card     = op;
      ifc.A        = a;
      ifc.B        = b;
      ifc.Cin      = cin;
      #1;
      while (!ifc.in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_accept"}, 64'(ifc.in_ready), 64'd1);
      if (ifc.in_ready) begin
         if (push) sb.push_back('{f: ef, c: ec, z: (ef == '0), lat: lat, acc: cyc + 1, name: name});
         @(posedge clk);
         #1;
      end
      ifc.in_valid = 1'b0;
      ifc.A        = $urandom;
      ifc.B        = $urandom;
      ifc.Cin      = ~cin;
      ifc.Card     = 5'($urandom);
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   function automatic void sweep_exp(input int op, output logic [W-1:0] f, output logic c,
                                     output int lat);
      f   = '0;
      c   = 1'b0;
      lat = 1;
      case (op)
         0:  c = 1'b1;
         1:  begin f = 32'h1;        c = 1'b1; end
         2:  begin f = 32'hFFFFFFFE; c = 1'b1; end
         3:  begin f = 32'hFFFFFFFD; c = 1'b1; end
         4:  f = 32'h1;
         5:  f = 32'hFFFFFFFF;
         6:  f = 32'hFFFFFFFE;
         8:  begin f = 32'hFFFFFFFE; c = 1'b1; end
         9:  begin f = 32'h7FFFFFFF; c = 1'b1; end
         10: begin f = 32'hFFFFFFFF; c = 1'b1; end
         12: f = 32'hFFFFFFFF;
         13: f = 32'h1;
         14: begin f = 32'hFFFFFFFF; lat = 33; end
         15: begin f = 32'hFFFFFFFF; lat = 33; end
         16: lat = 33;
         default: ;
      endcase
   endfunction

   initial begin : driver
      logic [W-1:0] ef;
      logic         ec;
      int           lat;
      bit           any;
      rst           = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      ifc.A         = '0;
      ifc.B         = '0;
      ifc.Cin       = 1'b0;
      ifc.Card      = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
      check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
      check("rst_F", 64'(ifc.F), 64'd0);
      check("rst_Cout", 64'(ifc.Cout), 64'd0);
      check("rst_Zero", 64'(ifc.Zero), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(5'd0,  32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,        1'b1, 1,  "add_wrap", 1);
      issue(5'd2,  32'h5,        32'h7, 1'b0, 32'hFFFFFFFE, 1'b0, 1,  "sub", 1);
      issue(5'd3,  32'h5,        32'h2, 1'b1, 32'h2,        1'b1, 1,  "subc", 1);
      issue(5'd14, 32'h7,        32'h6, 1'b0, 32'h2A,       1'b0, 33, "mul_7x6", 1);
      issue(5'd14, 32'h10000,    32'h10000, 1'b0, 32'h0,    1'b1, 33, "mul_ovf", 1);
      issue(5'd15, 32'd100,      32'd7, 1'b0, 32'hE,        1'b0, 33, "divu", 1);
      issue(5'd16, 32'd100,      32'd7, 1'b0, 32'h2,        1'b0, 33, "remu", 1);
      issue(5'd15, 32'd5,        32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1,  "divu_by0", 1);
      issue(5'd16, 32'd5,        32'd0, 1'b0, 32'h5,        1'b1, 1,  "remu_by0", 1);
      issue(5'd15, 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 1'b0, 33, "divu_max", 1);
      issue(5'd16, 32'hFFFFFFFF, 32'h10, 1'b0, 32'hF,       1'b0, 33, "remu_max", 1);
      issue(5'd8,  32'h12345678, 32'h4, 1'b0, 32'h23456780, 1'b1, 1,  "sll4", 1);
      issue(5'd8,  32'h12345678, 32'h20, 1'b0, 32'h12345678, 1'b0, 1, "sll_amt0", 1);
      issue(5'd10, 32'h80000000, 32'd31, 1'b0, 32'hFFFFFFFF, 1'b0, 1, "sra31", 1);
      drain(400);

      ifc.out_ready = 1'b0;
      issue(5'd14, 32'h12345, 32'h1000, 1'b0, 32'h12345000, 1'b0, 33, "mul_hold", 1);
      begin
         int n = 0;
         while (!ifc.out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      check("hold_wait", 64'(ifc.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 64'(ifc.out_valid), 64'd1);
         check("hold_F", 64'(ifc.F), 64'h12345000);
         check("hold_Cout", 64'(ifc.Cout), 64'd0);
         check("hold_in_ready", 64'(ifc.in_ready), 64'd0);
      end
      ifc.out_ready = 1'b1;
      issue(5'd0, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1, "add_b2b", 1);
      drain(100);

      issue(5'd14, 32'h7, 32'h6, 1'b0, 32'h2A, 1'b0, 33, "mul_abort", 0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", 64'(ifc.out_valid), 64'd0);
      check("abort_in_ready", 64'(ifc.in_ready), 64'd1);
      check("abort_F", 64'(ifc.F), 64'd0);
      any = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.out_valid) any = 1;
      end
      check("abort_no_result", 64'(any), 64'd0);

      for (int op = 0; op < 32; op++) begin
         sweep_exp(op, ef, ec, lat);
         issue(5'(op), 32'hFFFFFFFF, 32'h1, 1'b1, ef, ec, lat, $sformatf("sweep%0d", op), 1);
      end
      drain(400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
